// File: rtl/lightbike_pkg.sv
// Shared screen geometry, direction encoding and control-state encoding
// for the light-bike sprite pipeline.
package lightbike_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BOX      = 30;
    localparam int XMAX     = SCREEN_W - BOX;
    localparam int YMAX     = SCREEN_H - BOX;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CRASHED = 2'd2
    } state_t;

    // Opposite directions differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/xy_to_addr.sv
// Registered (x,y) -> y*640 + x pixel address using shift-add, with a
// one-cycle valid pulse carried alongside the address register.
module xy_to_addr
    import lightbike_pkg::*;
#(
    parameter int INIT_X = 100,
    parameter int INIT_Y = 200
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic        valid_in,
    output logic [18:0] addr,
    output logic        valid_out
);

    localparam logic [18:0] INIT_ADDR = 19'(INIT_Y * SCREEN_W + INIT_X);

    logic [18:0] sum;

    // addr tracks (x,y) every cycle; valid_out is valid_in delayed by the same
    // register, so it marks exactly the cycle an address from a step appears.
    // There is no backpressure: the consumer must take the pulse when it occurs.
    always_comb begin
        sum = ({10'd0, y} << 9) + ({10'd0, y} << 7) + {9'd0, x};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr      <= INIT_ADDR;
            valid_out <= 1'b0;
        end else begin
            addr      <= sum;
            valid_out <= valid_in;
        end
    end

endmodule

// File: rtl/bike_position_ctrl.sv
// Owns the bike box position: direction capture, frame-paced stepping with
// edge wrap, crash freeze, and the registered top-left pixel address.
module bike_position_ctrl
    import lightbike_pkg::*;
#(
    parameter int         INIT_X          = 100,
    parameter int         INIT_Y          = 200,
    parameter logic [1:0] INIT_DIR        = 2'd3,
    parameter int         STEP            = 2,
    parameter int         FRAMES_PER_MOVE = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        crash,
    output logic [18:0] startaddr,
    output logic [9:0]  pos_x,
    output logic [8:0]  pos_y,
    output logic [1:0]  dir,
    output logic        moved,
    output logic        running,
    output logic        crashed,
    output logic [1:0]  dbg_state
);

    localparam logic [9:0] X0       = 10'(INIT_X);
    localparam logic [8:0] Y0       = 9'(INIT_Y);
    localparam logic [9:0] STEP_X   = 10'(STEP);
    localparam logic [8:0] STEP_Y   = 9'(STEP);
    localparam logic [9:0] XMAX_V   = 10'(XMAX);
    localparam logic [8:0] YMAX_V   = 9'(YMAX);
    localparam logic [9:0] X_LIM    = 10'(XMAX - STEP);
    localparam logic [8:0] Y_LIM    = 9'(YMAX - STEP);
    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_MOVE - 1);

    state_t      state, state_nxt;
    logic [1:0]  pending_dir;
    logic [7:0]  frame_cnt;
    logic [1:0]  req;
    logic        req_vld;
    logic        step_now;
    logic        step_q;
    logic [9:0]  x_step;
    logic [8:0]  y_step;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (crash) state_nxt = CRASHED;
            CRASHED: if (start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_vld = btn_up | btn_down | btn_left | btn_right;
        req     = DIR_RIGHT;
        if (btn_up)        req = DIR_UP;
        else if (btn_down) req = DIR_DOWN;
        else if (btn_left) req = DIR_LEFT;
    end

    // Crash wins over a coincident step, so a step needs crash low.
    assign step_now = (state == RUN) && !crash && frame_tick && (frame_cnt == CNT_LAST);

    always_comb begin
        x_step = pos_x;
        y_step = pos_y;
        case (pending_dir)
            DIR_RIGHT: x_step = (pos_x > X_LIM)  ? 10'd0  : pos_x + STEP_X;
            DIR_LEFT:  x_step = (pos_x < STEP_X) ? XMAX_V : pos_x - STEP_X;
            DIR_DOWN:  y_step = (pos_y > Y_LIM)  ? 9'd0   : pos_y + STEP_Y;
            default:   y_step = (pos_y < STEP_Y) ? YMAX_V : pos_y - STEP_Y;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pos_x       <= X0;
            pos_y       <= Y0;
            dir         <= INIT_DIR;
            pending_dir <= INIT_DIR;
            frame_cnt   <= 8'd0;
            step_q      <= 1'b0;
        end else begin
            step_q <= step_now;
            case (state)
                IDLE: if (start) frame_cnt <= 8'd0;
                RUN: if (!crash) begin
                    if (req_vld && (req != reverse_dir(dir))) pending_dir <= req;
                    if (step_now) begin
                        frame_cnt <= 8'd0;
                        dir       <= pending_dir;
                        pos_x     <= x_step;
                        pos_y     <= y_step;
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                CRASHED: if (start) begin
                    pos_x       <= X0;
                    pos_y       <= Y0;
                    dir         <= INIT_DIR;
                    pending_dir <= INIT_DIR;
                end
                default: ;
            endcase
        end
    end

    xy_to_addr #(
        .INIT_X (INIT_X),
        .INIT_Y (INIT_Y)
    ) u_addr (
        .clock     (clock),
        .resetn    (resetn),
        .x         (pos_x),
        .y         (pos_y),
        .valid_in  (step_q),
        .addr      (startaddr),
        .valid_out (moved)
    );

    assign running   = (state == RUN);
    assign crashed   = (state == CRASHED);
    assign dbg_state = state;

endmodule

// File: tb/tb_bike_position_ctrl.sv
// Self-checking bench for bike_position_ctrl: directed scenarios with literal
// expectations followed by randomized stimulus against a behavioural model.
module tb_bike_position_ctrl;

    localparam int T_INIT_X = 100;
    localparam int T_INIT_Y = 200;
    localparam int T_STEP   = 2;
    localparam int T_FPM    = 2;
    localparam int T_XMAX   = 610;
    localparam int T_YMAX   = 450;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_CRASHED = 2;

    logic        clock;
    logic        resetn;
    logic        frame_tick;
    logic        start;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic        crash;
    logic [18:0] startaddr;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic [1:0]  dir;
    logic        moved;
    logic        running;
    logic        crashed;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // behavioural model state
    int m_st, m_x, m_y, m_dir, m_pend, m_cnt;
    int m_addr, m_moved, m_stepped;

    bike_position_ctrl dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .start      (start),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .crash      (crash),
        .startaddr  (startaddr),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .dir        (dir),
        .moved      (moved),
        .running    (running),
        .crashed    (crashed),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    // Behavioural reference: one update per clock from the sampled inputs.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_st = M_IDLE; m_x = T_INIT_X; m_y = T_INIT_Y;
            m_dir = 3; m_pend = 3; m_cnt = 0;
            m_addr = T_INIT_Y * 640 + T_INIT_X; m_moved = 0; m_stepped = 0;
        end else begin
            int n_addr, n_moved, old_pend, want;
            n_addr    = m_y * 640 + m_x;
            n_moved   = m_stepped;
            m_stepped = 0;
            case (m_st)
                M_IDLE: if (start) begin m_st = M_RUN; m_cnt = 0; end
                M_RUN: begin
                    if (crash) m_st = M_CRASHED;
                    else begin
                        old_pend = m_pend;
                        want = -1;
                        if (btn_up)         want = 0;
                        else if (btn_down)  want = 1;
                        else if (btn_left)  want = 2;
                        else if (btn_right) want = 3;
                        if (want >= 0 && want != opposite(m_dir)) m_pend = want;
                        if (frame_tick) begin
                            m_cnt++;
                            if (m_cnt == T_FPM) begin
                                m_cnt = 0;
                                m_dir = old_pend;
                                m_stepped = 1;
                                case (m_dir)
                                    3: m_x = (m_x + T_STEP > T_XMAX) ? 0 : m_x + T_STEP;
                                    2: m_x = (m_x - T_STEP < 0) ? T_XMAX : m_x - T_STEP;
                                    1: m_y = (m_y + T_STEP > T_YMAX) ? 0 : m_y + T_STEP;
                                    default: m_y = (m_y - T_STEP < 0) ? T_YMAX : m_y - T_STEP;
                                endcase
                            end
                        end
                    end
                end
                default: if (start) begin
                    m_st = M_IDLE; m_x = T_INIT_X; m_y = T_INIT_Y; m_dir = 3; m_pend = 3;
                end
            endcase
            m_addr  = n_addr;
            m_moved = n_moved;
        end
    end

    // scoreboard compare: every cycle, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            chk("startaddr", int'(startaddr), m_addr);
            chk("pos_x",     int'(pos_x),     m_x);
            chk("pos_y",     int'(pos_y),     m_y);
            chk("dir",       int'(dir),       m_dir);
            chk("moved",     int'(moved),     m_moved);
            chk("running",   int'(running),   int'(m_st == M_RUN));
            chk("crashed",   int'(crashed),   int'(m_st == M_CRASHED));
        end
    end

    // driver tasks (all return at a negedge)
    task automatic idle_cycle();
        @(negedge clock);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        @(negedge clock);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    endtask

    initial begin
        int guard;
        resetn = 1'b0; frame_tick = 0; start = 0; crash = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        chk_en = 1;
        chk("reset startaddr", int'(startaddr), 128100);
        chk("reset pos_x", int'(pos_x), 100);
        chk("reset dir", int'(dir), 3);

        // ticks in IDLE do nothing
        tick();
        chk("idle hold x", int'(pos_x), 100);

        // start, four ticks: steps on ticks 2 and 4
        do_start();
        tick();
        chk("tick1 no move", int'(moved), 0);
        tick();
        chk("tick2 moved", int'(moved), 1);
        chk("tick2 addr", int'(startaddr), 128102);
        tick();
        tick();
        chk("tick4 moved", int'(moved), 1);
        chk("tick4 addr", int'(startaddr), 128104);
        chk("tick4 dir", int'(dir), 3);

        // turn up from (104,200)
        press(1, 0, 0, 0);
        tick(); tick();
        chk("up y", int'(pos_y), 198);
        chk("up addr", int'(startaddr), 126824);
        chk("up dir", int'(dir), 0);

        // back to right, then reverse request ignored
        press(0, 0, 0, 1);
        tick(); tick();
        press(0, 0, 1, 0);
        tick(); tick();
        chk("reverse ignored dir", int'(dir), 3);
        chk("reverse ignored x", int'(pos_x), 108);

        // up beats right
        press(1, 0, 0, 1);
        tick(); tick();
        chk("priority dir", int'(dir), 0);
        chk("priority y", int'(pos_y), 196);

        // run right to the edge and wrap
        press(0, 0, 0, 1);
        guard = 0;
        while (m_x != T_XMAX && guard < 400) begin tick(); tick(); guard++; end
        chk("reach xmax", int'(pos_x), 610);
        tick(); tick();
        chk("wrap right x", int'(pos_x), 0);
        chk("wrap right addr", int'(startaddr), 125440);

        // down one step, then left wraps to XMAX
        press(0, 1, 0, 0);
        tick(); tick();
        press(0, 0, 1, 0);
        tick(); tick();
        chk("wrap left x", int'(pos_x), 610);
        chk("wrap left y", int'(pos_y), 198);

        // up to row 0 then wrap to YMAX
        press(1, 0, 0, 0);
        guard = 0;
        while (m_y != 0 && guard < 200) begin tick(); tick(); guard++; end
        chk("reach y0", int'(pos_y), 0);
        tick(); tick();
        chk("wrap up y", int'(pos_y), 450);
        chk("wrap up addr", int'(startaddr), 288610);

        // crash coincident with the move tick
        tick();
        frame_tick = 1'b1; crash = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0; crash = 1'b0;
        @(negedge clock);
        chk("crash moved", int'(moved), 0);
        chk("crash crashed", int'(crashed), 1);
        chk("crash y frozen", int'(pos_y), 450);
        tick(); tick();
        chk("crashed addr hold", int'(startaddr), 288610);

        // restart: position immediate, address one cycle later
        do_start();
        chk("restart x", int'(pos_x), 100);
        chk("restart crashed", int'(crashed), 0);
        chk("restart addr lag", int'(startaddr), 288610);
        idle_cycle();
        chk("restart addr", int'(startaddr), 128100);

        // asynchronous reset mid-run
        do_start();
        press(0, 1, 0, 0);
        tick(); tick();
        #2 resetn = 1'b0;
        #1;
        chk("async rst x", int'(pos_x), 100);
        chk("async rst y", int'(pos_y), 200);
        chk("async rst running", int'(running), 0);
        chk("async rst addr", int'(startaddr), 128100);
        @(negedge clock);
        resetn = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            start      = ($urandom_range(0, 19) == 0);
            crash      = ($urandom_range(0, 149) == 0);
            btn_up     = ($urandom_range(0, 9) == 0);
            btn_down   = ($urandom_range(0, 9) == 0);
            btn_left   = ($urandom_range(0, 9) == 0);
            btn_right  = ($urandom_range(0, 9) == 0);
            @(negedge clock);
        end
        frame_tick = 0; start = 0; crash = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        idle_cycle();
        idle_cycle();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
